// File: rtl/keypad_encoder_if.sv
// Token stream between the keypad encoder (master) and its consumer (slave).
interface keypad_encoder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] code_out;
  logic             code_valid;
  logic             code_ready;

  modport master (output code_out, output code_valid, input code_ready);
  modport slave  (input code_out, input code_valid, output code_ready);
endinterface

// File: rtl/keypad_encoder.sv
// Keypad encoder: synchronises and debounces raw token/control keys, encodes
// the lowest-index pressed token key into a FIFO, pulses control keys.
// Optional auto-repeat is built when KEYPAD_TYPEMATIC_EN is defined.
module keypad_encoder #(
  parameter int WIDTH        = 8,
  parameter int NKEYS        = 16,
  parameter int NCTRL        = 4,
  parameter int DEBOUNCE     = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NKEYS-1:0]              b,
  input  logic [NCTRL-1:0]              ctrl,
  keypad_encoder_if.master              tok,
  output logic [NCTRL-1:0]              ctrl_pulse,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int NIN  = NKEYS + NCTRL;
  localparam int DCW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int IDXW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  // Elaboration-time parameter legality checks
  generate
    if (WIDTH < 8) begin : g_chk_width
      $error("keypad_encoder: WIDTH must be >= 8");
    end
    if (NKEYS < 1 || NKEYS > 64) begin : g_chk_nkeys
      $error("keypad_encoder: NKEYS must be 1..64");
    end
    if (DEBOUNCE < 1) begin : g_chk_deb
      $error("keypad_encoder: DEBOUNCE must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
      $error("keypad_encoder: FIFO_DEPTH must be a power of two >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_chk_rep
      $error("keypad_encoder: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Synchroniser and debounce, token keys in the low bits, control above
  // ---------------------------------------------------------------------
  logic [NIN-1:0] r_sync1, r_sync2, r_deb;
  logic [DCW-1:0] r_cnt [NIN];

  // Two-flop synchroniser for every raw key
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {ctrl, b};
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit down-counter; debounced bit flips after DEBOUNCE differing cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_deb <= '0;
      for (int i = 0; i < NIN; i++) r_cnt[i] <= DCW'(DEBOUNCE - 1);
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= DCW'(DEBOUNCE - 1);
        end else if (r_cnt[i] == '0) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= DCW'(DEBOUNCE - 1);
        end else begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  logic [NKEYS-1:0] w_tok_deb;
  logic [NCTRL-1:0] w_ctrl_deb;
  assign w_tok_deb  = r_deb[NKEYS-1:0];
  assign w_ctrl_deb = r_deb[NIN-1:NKEYS];

  // ---------------------------------------------------------------------
  // Control-key rising-edge pulses
  // ---------------------------------------------------------------------
  logic [NCTRL-1:0] r_ctrl_deb_q, r_ctrl_pulse;

  // One-cycle pulse on each debounced control-key press
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl_deb_q <= '0;
      r_ctrl_pulse <= '0;
    end else begin
      r_ctrl_deb_q <= w_ctrl_deb;
      r_ctrl_pulse <= w_ctrl_deb & ~r_ctrl_deb_q;
    end
  end

  assign ctrl_pulse = r_ctrl_pulse;

  // ---------------------------------------------------------------------
  // Priority encode and press event
  // ---------------------------------------------------------------------
  logic [IDXW-1:0] w_idx;
  logic [7:0]      w_tok8;
  logic [WIDTH-1:0] w_token;
  logic            w_any;
  logic            r_tok_any_q;
  logic            w_event;

  // Lowest-index pressed key wins: scan downwards so the last hit is lowest
  always_comb begin
    w_idx  = '0;
    w_tok8 = 8'h00;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (w_tok_deb[i]) begin
        w_idx  = IDXW'(i);
        w_tok8 = (i < 10) ? 8'(i) : 8'(160 + i - 10);
      end
    end
  end

  assign w_token = WIDTH'(w_tok8);
  assign w_any   = |w_tok_deb;
  assign w_event = w_any & ~r_tok_any_q;

  // Remember whether any token key was held last cycle (no-rollover detect)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_tok_any_q <= 1'b0;
    else          r_tok_any_q <= w_any;
  end

  logic w_push;

`ifdef KEYPAD_TYPEMATIC_EN
  // ---------------------------------------------------------------------
  // Auto-repeat FSM
  //   state    | meaning
  //   S_IDLE   | no key held, waiting for a press event
  //   S_HOLD   | key held, counting down the initial repeat delay
  //   S_REPEAT | repeating the held token every REPEAT_RATE cycles
  // ---------------------------------------------------------------------
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} rep_state_t;

  rep_state_t      r_state, w_state_nxt;
  logic [RCW-1:0]  r_rep_cnt, w_rep_cnt_nxt;
  logic [IDXW-1:0] r_held_idx, w_held_nxt;
  logic            w_rep_emit;
  logic            w_key_chg;

  assign w_key_chg = ~w_any | (w_idx != r_held_idx);

  // Repeat FSM state, timer and held key registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rep_cnt  <= '0;
      r_held_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
      r_held_idx <= w_held_nxt;
    end
  end

  // Repeat FSM next state; timer reloads with N-1 so expiry lands N cycles later
  always_comb begin
    w_state_nxt   = r_state;
    w_rep_cnt_nxt = r_rep_cnt;
    w_held_nxt    = r_held_idx;
    w_rep_emit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_event) begin
          w_state_nxt   = S_HOLD;
          w_rep_cnt_nxt = RCW'(REPEAT_DELAY - 1);
          w_held_nxt    = w_idx;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (w_key_chg) begin
          w_state_nxt = S_IDLE;
        end else if (r_rep_cnt == '0) begin
          w_state_nxt   = S_REPEAT;
          w_rep_emit    = 1'b1;
          w_rep_cnt_nxt = RCW'(REPEAT_RATE - 1);
        end else begin
          w_rep_cnt_nxt = r_rep_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_push = w_event | w_rep_emit;
`else
  assign w_push = w_event;
`endif

  // ---------------------------------------------------------------------
  // Token FIFO
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_full, w_empty, w_pop, w_wr, w_drop;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & tok.code_ready;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_token;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign tok.code_out   = r_mem[r_rd_ptr];
  assign tok.code_valid = ~w_empty;
  assign fifo_count     = r_count;
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder (default build, DEBOUNCE=4, FIFO_DEPTH=4).
module tb_keypad_encoder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] b;
  logic [3:0]  ctrl;
  logic [3:0]  ctrl_pulse;
  logic        overflow;
  logic        ovf_clr;
  logic [2:0]  fifo_count;

  keypad_encoder_if #(.WIDTH(8)) tok ();

  keypad_encoder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .b          (b),
    .ctrl       (ctrl),
    .tok        (tok),
    .ctrl_pulse (ctrl_pulse),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and direct checks happen 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int k);
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (tok.code_valid) begin
        k = i;
        break;
      end
    end
  endtask

  // Monitor: every accepted token is compared with the scoreboard head
  always @(negedge clock) begin
    if (reset_n && tok.code_valid && tok.code_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_token: got 0x%0h, expected none", tok.code_out);
      end else begin
        check("token", {24'h0, tok.code_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int  k;
    bit  seen;

    reset_n = 1'b0;
    b = '0;
    ctrl = '0;
    ovf_clr = 1'b0;
    tok.code_ready = 1'b0;
    repeat (3) tick();

    check("rst_valid", {31'h0, tok.code_valid}, 0);
    check("rst_ctrl_pulse", {28'h0, ctrl_pulse}, 0);
    check("rst_overflow", {31'h0, overflow}, 0);
    check("rst_fifo_count", {29'h0, fifo_count}, 0);
    check("rst_code_out", {24'h0, tok.code_out}, 0);

    reset_n = 1'b1;
    repeat (2) tick();

    // b[3] held 20 cycles: token 03 seven edges after the press, one cycle wide
    tok.code_ready = 1'b1;
    exp_q.push_back(8'h03);
    b[3] = 1'b1;
    wait_valid(k);
    check("b3_latency", k, 7);
    tick();
    check("b3_valid_one_cycle", {31'h0, tok.code_valid}, 0);
    repeat (12) tick();
    b[3] = 1'b0;
    repeat (12) tick();

    // 3-cycle glitch on b[5] must be filtered
    seen = 1'b0;
    b[5] = 1'b1;
    repeat (3) tick();
    b[5] = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (tok.code_valid || ctrl_pulse != 4'h0) seen = 1'b1;
    end
    check("glitch_filtered", {31'h0, seen}, 0);

    // b[12]+b[2] together -> 02 only; b[12] re-press while b[2] held -> nothing
    exp_q.push_back(8'h02);
    b[12] = 1'b1;
    b[2]  = 1'b1;
    repeat (12) tick();
    b[12] = 1'b0;
    repeat (10) tick();
    b[12] = 1'b1;
    repeat (12) tick();
    b = '0;
    repeat (12) tick();
    check("rollover_queue_empty", exp_q.size(), 0);
    check("rollover_fifo_count", {29'h0, fifo_count}, 0);

    // Five presses of b[10] with no consumer: four queued, one dropped
    tok.code_ready = 1'b0;
    repeat (4) exp_q.push_back(8'hA0);
    for (int p = 0; p < 5; p++) begin
      b[10] = 1'b1;
      repeat (10) tick();
      b[10] = 1'b0;
      repeat (10) tick();
    end
    check("full_fifo_count", {29'h0, fifo_count}, 4);
    check("full_overflow", {31'h0, overflow}, 1);
    check("full_head", {24'h0, tok.code_out}, 32'hA0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'h0, overflow}, 0);

    // Next press lands on the same edge as a pop: accepted, count stays 4
    exp_q.push_back(8'hA0);
    b[10] = 1'b1;
    repeat (6) tick();
    tok.code_ready = 1'b1;
    tick();
    tok.code_ready = 1'b0;
    check("push_pop_fifo_count", {29'h0, fifo_count}, 4);
    check("push_pop_overflow", {31'h0, overflow}, 0);
    repeat (5) tick();
    b[10] = 1'b0;
    repeat (10) tick();
    tok.code_ready = 1'b1;
    repeat (8) tick();
    check("drain_fifo_count", {29'h0, fifo_count}, 0);
    check("drain_queue_empty", exp_q.size(), 0);

    // ctrl[0]+ctrl[3] together with b[7] held, consumer stalled
    tok.code_ready = 1'b0;
    b[7] = 1'b1;
    ctrl = 4'b1001;
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ctrl_pulse != 4'h0) begin
        k = i;
        break;
      end
    end
    check("ctrl_latency", k, 7);
    check("ctrl_pulse_value", {28'h0, ctrl_pulse}, 32'h9);
    check("ctrl_token_same_edge", {31'h0, tok.code_valid}, 1);
    tick();
    check("ctrl_pulse_one_cycle", {28'h0, ctrl_pulse}, 0);
    check("held_fifo_count", {29'h0, fifo_count}, 1);
    repeat (3) tick();

    // Reset mid-hold clears all outputs at once
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'h0, tok.code_valid}, 0);
    check("midrst_ctrl_pulse", {28'h0, ctrl_pulse}, 0);
    check("midrst_overflow", {31'h0, overflow}, 0);
    check("midrst_fifo_count", {29'h0, fifo_count}, 0);
    check("midrst_code_out", {24'h0, tok.code_out}, 0);
    repeat (3) tick();

    // Keys still held after reset release are a fresh press
    exp_q.push_back(8'h07);
    tok.code_ready = 1'b1;
    reset_n = 1'b1;
    wait_valid(k);
    check("post_rst_latency", k, 7);
    check("post_rst_ctrl_pulse", {28'h0, ctrl_pulse}, 32'h9);
    b = '0;
    ctrl = '0;
    repeat (12) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
